// File: rtl/wash_sequencer.sv
// wash_sequencer
// Sequences one wash programme: FILL -> WASH -> DRAIN -> SPIN -> IDLE
// (spin-only programme: SPIN -> IDLE). Every phase is timed in whole
// seconds by a prescaler that produces one tick per CLK_PER_SEC cycles.
//
// Ports
//   clk        system clock, rising edge
//   rst        asynchronous active-low reset
//   start      one-cycle pulse, accepted only in IDLE (mode latched then)
//   mode[1:0]  00 spin-only, 01 small, 10 medium, 11 large
//   pause      level, freezes the running phase
//   door_open  level, freezes FILL/WASH/DRAIN; in SPIN it trips ERROR
//   abort      one-cycle pulse, returns any non-IDLE state to IDLE
//   phase[2:0] current state (also the FSM debug view): 000 IDLE, 001 FILL,
//              010 WASH, 011 DRAIN, 100 SPIN, 111 ERROR
//   remain[7:0] seconds left in the current phase
//   valve, drain, motor[1:0]  actuators (off whenever held)
//   busy, held, fault, done   status; done is a one-cycle completion pulse
//
// Control pulses: start and abort are sampled on every rising edge and
// act exactly once per cycle they are high; there is no back-pressure, a
// pulse arriving in a state that does not accept it is simply dropped.

module wash_sequencer #(
  parameter int CLK_PER_SEC = 100000000,
  parameter int T_FILL      = 4,
  parameter int T_WASH_S    = 6,
  parameter int T_WASH_M    = 10,
  parameter int T_WASH_L    = 14,
  parameter int T_DRAIN     = 3,
  parameter int T_SPIN      = 5
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [1:0] mode,
  input  logic       pause,
  input  logic       door_open,
  input  logic       abort,
  output logic [2:0] phase,
  output logic [7:0] remain,
  output logic       valve,
  output logic       drain,
  output logic       busy,
  output logic       held,
  output logic       fault,
  output logic       done,
  output logic [1:0] motor
);

  localparam int PW = (CLK_PER_SEC > 1) ? $clog2(CLK_PER_SEC) : 1;
  localparam logic [PW-1:0] PRESC_LAST = PW'(CLK_PER_SEC - 1);

  // Encoding matches the phase output code so phase is the raw state.
  typedef enum logic [2:0] {
    S_IDLE  = 3'b000,
    S_FILL  = 3'b001,
    S_WASH  = 3'b010,
    S_DRAIN = 3'b011,
    S_SPIN  = 3'b100,
    S_ERROR = 3'b111
  } state_t;

  state_t          state_q, state_d;
  logic [7:0]      remain_q, remain_d;
  logic [PW-1:0]   presc_q, presc_d;
  logic [1:0]      mode_q, mode_d;
  logic            done_q, done_d;
  logic            running;
  logic            frozen;
  logic            tick;

  function automatic logic [7:0] phase_len(input state_t s, input logic [1:0] m);
    logic [7:0] len;
    len = 8'd0;
    case (s)
      S_FILL:  len = 8'(T_FILL);
      S_WASH: begin
        case (m)
          2'b01:   len = 8'(T_WASH_S);
          2'b10:   len = 8'(T_WASH_M);
          default: len = 8'(T_WASH_L);
        endcase
      end
      S_DRAIN: len = 8'(T_DRAIN);
      S_SPIN:  len = 8'(T_SPIN);
      default: len = 8'd0;
    endcase
    return len;
  endfunction

  // Every programme ends with DRAIN -> SPIN -> IDLE, so the successor
  // does not depend on mode; spin-only simply enters at SPIN.
  function automatic state_t next_phase(input state_t s);
    state_t n;
    case (s)
      S_FILL:  n = S_WASH;
      S_WASH:  n = S_DRAIN;
      S_DRAIN: n = S_SPIN;
      default: n = S_IDLE;
    endcase
    return n;
  endfunction

  assign running = (state_q == S_FILL) || (state_q == S_WASH) ||
                   (state_q == S_DRAIN) || (state_q == S_SPIN);
  assign frozen  = running && (pause || door_open);
  assign tick    = (presc_q == PRESC_LAST);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= S_IDLE;
      remain_q <= 8'd0;
      presc_q  <= '0;
      mode_q   <= 2'b00;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      remain_q <= remain_d;
      presc_q  <= presc_d;
      mode_q   <= mode_d;
      done_q   <= done_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    remain_d = remain_q;
    presc_d  = presc_q;
    mode_d   = mode_q;
    done_d   = 1'b0;

    if (state_q == S_IDLE) begin
      // abort is meaningless here, so start always wins
      if (start) begin
        mode_d   = mode;
        state_d  = (mode == 2'b00) ? S_SPIN : S_FILL;
        remain_d = phase_len(state_d, mode);
        presc_d  = '0;
      end
    end else if (abort) begin
      state_d  = S_IDLE;
      remain_d = 8'd0;
      presc_d  = '0;
    end else if (state_q == S_ERROR) begin
      state_d = S_ERROR;
    end else if ((state_q == S_SPIN) && door_open) begin
      state_d  = S_ERROR;
      remain_d = 8'd0;
      presc_d  = '0;
    end else if (frozen) begin
      state_d = state_q;
    end else if (tick) begin
      presc_d = '0;
      // <= 1 rather than == 1 so a zero-length phase can never wrap remain
      if (remain_q <= 8'd1) begin
        state_d  = next_phase(state_q);
        remain_d = phase_len(state_d, mode_q);
        done_d   = (state_q == S_SPIN);
      end else begin
        remain_d = remain_q - 8'd1;
      end
    end else begin
      presc_d = presc_q + PW'(1);
    end
  end

  assign phase  = state_q;
  assign remain = remain_q;
  assign done   = done_q;
  assign busy   = (state_q != S_IDLE);
  assign held   = frozen;
  assign fault  = (state_q == S_ERROR);
  assign valve  = (state_q == S_FILL) && !frozen;
  assign drain  = ((state_q == S_DRAIN) || (state_q == S_SPIN)) && !frozen;
  assign motor  = frozen              ? 2'b00 :
                  (state_q == S_WASH) ? 2'b01 :
                  (state_q == S_SPIN) ? 2'b10 : 2'b00;

endmodule

// File: tb/tb_wash_sequencer.sv
// Directed bench for wash_sequencer with CLK_PER_SEC = 4.
// A schedule model (phase + running cycles elapsed in that phase) predicts
// every output; one process compares it on each falling edge, while the
// directed sequence pins phase lengths and key values with literals.

module tb_wash_sequencer;

  localparam int CPS      = 4;
  localparam int T_FILL   = 4;
  localparam int T_WASH_S = 6;
  localparam int T_WASH_M = 10;
  localparam int T_WASH_L = 14;
  localparam int T_DRAIN  = 3;
  localparam int T_SPIN   = 5;

  // ---------------- clock / reset ----------------
  logic       clk = 1'b0;
  logic       rst;
  logic       start, pause, door_open, abort;
  logic [1:0] mode;
  logic [2:0] phase;
  logic [7:0] remain;
  logic       valve, drain, busy, held, fault, done;
  logic [1:0] motor;

  always #5 clk = ~clk;

  wash_sequencer #(
    .CLK_PER_SEC(CPS), .T_FILL(T_FILL), .T_WASH_S(T_WASH_S),
    .T_WASH_M(T_WASH_M), .T_WASH_L(T_WASH_L), .T_DRAIN(T_DRAIN),
    .T_SPIN(T_SPIN)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .mode(mode), .pause(pause),
    .door_open(door_open), .abort(abort), .phase(phase), .remain(remain),
    .valve(valve), .drain(drain), .busy(busy), .held(held), .fault(fault),
    .done(done), .motor(motor)
  );

  // ---------------- scoreboard counters ----------------
  int tests = 0;
  int fails = 0;

  task automatic chk(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // Phase codes: 0 idle, 1 fill, 2 wash, 3 drain, 4 spin, 7 error.
  int m_phase, m_elapsed, m_mode;
  bit m_done;

  function automatic int m_dur(input int p, input int md);
    case (p)
      1: return T_FILL;
      2: return (md == 1) ? T_WASH_S : (md == 2) ? T_WASH_M : T_WASH_L;
      3: return T_DRAIN;
      4: return T_SPIN;
      default: return 0;
    endcase
  endfunction

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_phase = 0; m_elapsed = 0; m_mode = 0; m_done = 0;
    end else begin
      m_done = 0;
      if (m_phase == 0) begin
        if (start) begin
          m_mode    = int'(mode);
          m_phase   = (mode == 2'b00) ? 4 : 1;
          m_elapsed = 0;
        end
      end else if (abort) begin
        m_phase = 0; m_elapsed = 0;
      end else if (m_phase == 7) begin
        m_phase = 7;
      end else if (m_phase == 4 && door_open) begin
        m_phase = 7;
      end else if (!(pause || door_open)) begin
        m_elapsed++;
        if (m_elapsed >= m_dur(m_phase, m_mode) * CPS) begin
          m_done    = (m_phase == 4);
          m_phase   = (m_phase == 4) ? 0 : m_phase + 1;
          m_elapsed = 0;
        end
      end
    end
  end

  bit e_run, e_hold;
  int e_remain;

  always @(negedge clk) begin
    e_run    = (m_phase >= 1) && (m_phase <= 4);
    e_hold   = e_run && (pause || door_open);
    e_remain = e_run ? m_dur(m_phase, m_mode) - m_elapsed / CPS : 0;
    chk("phase",  int'(phase),  m_phase);
    chk("remain", int'(remain), e_remain);
    chk("valve",  int'(valve),  int'(m_phase == 1 && !e_hold));
    chk("drain",  int'(drain),  int'((m_phase == 3 || m_phase == 4) && !e_hold));
    chk("motor",  int'(motor),  e_hold ? 0 : (m_phase == 2) ? 1 : (m_phase == 4) ? 2 : 0);
    chk("busy",   int'(busy),   int'(m_phase != 0));
    chk("held",   int'(held),   int'(e_hold));
    chk("fault",  int'(fault),  int'(m_phase == 7));
    chk("done",   int'(done),   int'(m_done));
  end

  // ---------------- driver tasks ----------------
  task automatic step(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic pulse_start(input logic [1:0] md);
    mode  = md;
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  task automatic pulse_abort();
    abort = 1'b1;
    step();
    abort = 1'b0;
  endtask

  // Counts cycles spent in phase p (bounded), compares with a literal.
  task automatic measure(input int p, input string name, input int exp);
    int n = 0;
    while (int'(phase) == p && n < 300) begin
      step();
      n++;
    end
    chk(name, n, exp);
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    fails++;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $fatal(1, "watchdog");
  end

  // ---------------- directed sequence ----------------
  initial begin
    rst = 1'b1; start = 1'b0; abort = 1'b0; pause = 1'b0;
    door_open = 1'b0; mode = 2'b00;
    #1 rst = 1'b0;
    step(2);
    chk("rst_phase", int'(phase), 0);
    chk("rst_remain", int'(remain), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    rst = 1'b1;
    step(2);

    // small programme, full run
    pulse_start(2'b01);
    chk("s_fill_phase", int'(phase), 1);
    chk("s_fill_remain", int'(remain), 4);
    chk("s_fill_valve", int'(valve), 1);
    measure(1, "s_fill_len", 16);
    chk("s_wash_remain", int'(remain), 6);
    chk("s_wash_motor", int'(motor), 1);
    measure(2, "s_wash_len", 24);
    chk("s_drain_remain", int'(remain), 3);
    measure(3, "s_drain_len", 12);
    chk("s_spin_remain", int'(remain), 5);
    chk("s_spin_motor", int'(motor), 2);
    chk("s_spin_drain", int'(drain), 1);
    measure(4, "s_spin_len", 20);
    chk("s_end_phase", int'(phase), 0);
    chk("s_end_done", int'(done), 1);
    step();
    chk("s_done_once", int'(done), 0);

    // spin-only
    pulse_start(2'b00);
    chk("so_phase", int'(phase), 4);
    chk("so_remain", int'(remain), 5);
    chk("so_motor", int'(motor), 2);
    measure(4, "so_spin_len", 20);
    chk("so_done", int'(done), 1);
    step();

    // large programme; mode changed after start must be ignored
    pulse_start(2'b11);
    mode = 2'b00;
    measure(1, "l_fill_len", 16);
    measure(2, "l_wash_len", 56);
    pulse_abort();
    chk("l_abort_phase", int'(phase), 0);
    chk("l_abort_done", int'(done), 0);
    step();

    // medium wash paused at remain 7
    pulse_start(2'b10);
    measure(1, "m_fill_len", 16);
    step(12);
    chk("m_wash_remain7", int'(remain), 7);
    pause = 1'b1;
    step(9);
    chk("m_pause_remain", int'(remain), 7);
    chk("m_pause_motor", int'(motor), 0);
    chk("m_pause_held", int'(held), 1);
    pause = 1'b0;
    measure(2, "m_wash_rest", 28);
    pulse_abort();

    // door open during fill freezes it
    pulse_start(2'b01);
    step(5);
    door_open = 1'b1;
    step(7);
    chk("d_fill_remain", int'(remain), 3);
    chk("d_fill_valve", int'(valve), 0);
    chk("d_fill_held", int'(held), 1);
    door_open = 1'b0;
    measure(1, "d_fill_rest", 11);
    pulse_abort();

    // door open during spin trips ERROR
    pulse_start(2'b00);
    step(3);
    door_open = 1'b1;
    step();
    chk("e_phase", int'(phase), 7);
    chk("e_fault", int'(fault), 1);
    chk("e_remain", int'(remain), 0);
    chk("e_motor", int'(motor), 0);
    chk("e_busy", int'(busy), 1);
    mode = 2'b01; start = 1'b1;
    step();
    start = 1'b0;
    chk("e_start_ignored", int'(phase), 7);
    door_open = 1'b0;
    step(2);
    chk("e_sticky", int'(phase), 7);
    pulse_abort();
    chk("e_abort_phase", int'(phase), 0);
    chk("e_abort_fault", int'(fault), 0);
    chk("e_abort_done", int'(done), 0);
    step();
    chk("e_no_done", int'(done), 0);

    // abort on the final fill tick, then start+abort together in IDLE
    pulse_start(2'b01);
    step(15);
    abort = 1'b1;
    step();
    abort = 1'b0;
    chk("a_tick_phase", int'(phase), 0);
    chk("a_tick_done", int'(done), 0);
    mode = 2'b01; start = 1'b1; abort = 1'b1;
    step();
    start = 1'b0; abort = 1'b0;
    chk("a_both_phase", int'(phase), 1);
    chk("a_both_remain", int'(remain), 4);
    pulse_abort();

    // reset during drain
    pulse_start(2'b01);
    measure(1, "r_fill_len", 16);
    measure(2, "r_wash_len", 24);
    step(5);
    #2 rst = 1'b0;
    #1;
    chk("r_phase", int'(phase), 0);
    chk("r_remain", int'(remain), 0);
    chk("r_drain", int'(drain), 0);
    chk("r_busy", int'(busy), 0);
    chk("r_motor", int'(motor), 0);
    chk("r_done", int'(done), 0);
    step(3);
    rst = 1'b1;
    step(3);
    chk("r_after_done", int'(done), 0);
    chk("r_after_phase", int'(phase), 0);
    pulse_start(2'b01);
    chk("r_fresh_phase", int'(phase), 1);
    chk("r_fresh_remain", int'(remain), 4);
    measure(1, "r_fresh_fill", 16);
    pulse_abort();
    step(2);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/wash_sequencer.md
WASH_SEQUENCER -- requirements
Module: wash_sequencer

Interface
REQ-001 SHALL have parameter CLK_PER_SEC, default 100000000, clock cycles per one-second tick.
REQ-002 SHALL have parameter T_FILL, default 4, fill phase length in seconds.
REQ-003 SHALL have parameters T_WASH_S / T_WASH_M / T_WASH_L, defaults 6 / 10 / 14, wash length in seconds for small / medium / large.
REQ-004 SHALL have parameters T_DRAIN and T_SPIN, defaults 3 and 5, drain and spin lengths in seconds.
REQ-005 clk  input  1  system clock; all state changes on rising edge.
REQ-006 rst  input  1  asynchronous, active-low reset.
REQ-007 start  input  1  one-cycle pulse: payment confirmed, begin programme.
REQ-008 mode  input  2  programme: 00 spin-only, 01 small, 10 medium, 11 large.
REQ-009 pause  input  1  level, user pause request.
REQ-010 door_open  input  1  level, door interlock open.
REQ-011 abort  input  1  one-cycle pulse, cancel programme.
REQ-012 phase  output  3  000 IDLE, 001 FILL, 010 WASH, 011 DRAIN, 100 SPIN, 111 ERROR.
REQ-013 remain  output  8  seconds left in the current phase, binary.
REQ-014 valve, drain, busy, held, fault, done  output  1 each: water valve, drain pump, programme active, frozen, interlock fault, completion pulse.
REQ-015 motor  output  2  00 off, 01 slow (WASH), 10 fast (SPIN).

Function
REQ-016 SHALL latch mode on the cycle start is accepted; later mode changes SHALL NOT affect the running programme.
REQ-017 SHALL accept start only in IDLE; start in any other state SHALL be ignored.
REQ-018 Sequence for modes 01/10/11 SHALL be FILL -> WASH -> DRAIN -> SPIN -> IDLE; mode 00 SHALL be SPIN -> IDLE.
REQ-019 On phase entry, remain SHALL load that phase's duration and the prescaler SHALL clear to 0.
REQ-020 Prescaler SHALL count 0..CLK_PER_SEC-1 while running; a tick occurs on the terminal count, and remain SHALL decrement by 1 on each tick.
REQ-021 A tick with remain==1 SHALL enter the next phase on the same edge, so each phase lasts exactly duration*CLK_PER_SEC cycles.
REQ-022 Leaving SPIN SHALL enter IDLE and assert done for exactly one cycle.
REQ-023 Outputs SHALL be decoded from state: valve=1 in FILL, motor=01 in WASH, drain=1 in DRAIN, motor=10 and drain=1 in SPIN; otherwise 0.
REQ-024 busy SHALL be 1 in FILL, WASH, DRAIN, SPIN and ERROR, 0 in IDLE.
REQ-025 In FILL/WASH/DRAIN, pause=1 or door_open=1 SHALL freeze prescaler and remain, force valve, drain and motor to 0, and set held=1; releasing both SHALL resume from the frozen count.
REQ-026 door_open=1 during SPIN SHALL enter ERROR on the next edge: fault=1, remain=0, all actuators off.
REQ-027 pause=1 during SPIN SHALL freeze as in REQ-025; door_open takes priority over pause.
REQ-028 ERROR SHALL be left only by abort or reset, both returning to IDLE with fault=0.
REQ-029 abort in any non-IDLE state SHALL enter IDLE on the next edge, with done not asserted; abort has priority over tick, pause and door_open.
REQ-030 abort in IDLE SHALL be ignored; simultaneous start and abort in IDLE SHALL start the programme.
REQ-031 remain SHALL never wrap below 0.

Reset
REQ-032 rst=0 SHALL asynchronously force IDLE, phase=000, remain=0, prescaler=0, valve=drain=busy=held=fault=done=0, motor=00, latched mode=00.
REQ-033 Reset asserted mid-programme SHALL abandon it with no done pulse; the first start after rst returns high SHALL begin a fresh programme.

Verification (CLK_PER_SEC=4)
REQ-034 mode=01, start pulse -> FILL remain=4 for 16 cycles, WASH 24, DRAIN 12, SPIN 20, then IDLE with done high for one cycle.
REQ-035 mode=00, start -> SPIN directly, remain=5, motor=10, done after 20 cycles.
REQ-036 WASH remain=7, pause high 9 cycles -> remain holds 7, motor=00, held=1; release -> resumes and WASH still totals 40 running cycles.
REQ-037 door_open=1 in SPIN -> phase=111, fault=1, start ignored; abort -> IDLE, fault=0, no done.
REQ-038 abort coinciding with the final FILL tick -> IDLE, not WASH; start+abort in IDLE -> FILL.
REQ-039 rst low during DRAIN -> immediate IDLE, all outputs 0, no done pulse.
